// File: rtl/bus_dest_regs_pkg.sv
// Shared bus code definitions for the destination-register block and the source mux.
// Codes select one of 16 processor registers, the memory port, or nothing.
package bus_dest_regs_pkg;

  localparam int CODE_W   = 5;
  localparam int NUM_REGS = 16;

  typedef enum logic [CODE_W-1:0] {
    CODE_NONE = 5'b00000,
    CODE_AC   = 5'b00001,
    CODE_C3   = 5'b00010,
    CODE_C2   = 5'b00011,
    CODE_C1   = 5'b00100,
    CODE_RN2  = 5'b00101,
    CODE_RK2  = 5'b00110,
    CODE_RM2  = 5'b00111,
    CODE_RN1  = 5'b01000,
    CODE_RK1  = 5'b01001,
    CODE_RM1  = 5'b01010,
    CODE_RT   = 5'b01011,
    CODE_RP   = 5'b01100,
    CODE_DR   = 5'b01101,
    CODE_AR   = 5'b01110,
    CODE_MEM  = 5'b01111,
    CODE_RR   = 5'b10000,
    CODE_RT4  = 5'b10001
  } bus_code_e;

  // Register slot order inside the register file.
  localparam int IDX_AC  = 0;
  localparam int IDX_C3  = 1;
  localparam int IDX_C2  = 2;
  localparam int IDX_C1  = 3;
  localparam int IDX_RN2 = 4;
  localparam int IDX_RK2 = 5;
  localparam int IDX_RM2 = 6;
  localparam int IDX_RN1 = 7;
  localparam int IDX_RK1 = 8;
  localparam int IDX_RM1 = 9;
  localparam int IDX_RT  = 10;
  localparam int IDX_RP  = 11;
  localparam int IDX_DR  = 12;
  localparam int IDX_AR  = 13;
  localparam int IDX_RR  = 14;
  localparam int IDX_RT4 = 15;

  // MEM and NONE codes map to no register slot.
  function automatic logic [NUM_REGS-1:0] code_onehot(input logic [CODE_W-1:0] code);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    case (code)
      CODE_AC:  oh[IDX_AC]  = 1'b1;
      CODE_C3:  oh[IDX_C3]  = 1'b1;
      CODE_C2:  oh[IDX_C2]  = 1'b1;
      CODE_C1:  oh[IDX_C1]  = 1'b1;
      CODE_RN2: oh[IDX_RN2] = 1'b1;
      CODE_RK2: oh[IDX_RK2] = 1'b1;
      CODE_RM2: oh[IDX_RM2] = 1'b1;
      CODE_RN1: oh[IDX_RN1] = 1'b1;
      CODE_RK1: oh[IDX_RK1] = 1'b1;
      CODE_RM1: oh[IDX_RM1] = 1'b1;
      CODE_RT:  oh[IDX_RT]  = 1'b1;
      CODE_RP:  oh[IDX_RP]  = 1'b1;
      CODE_DR:  oh[IDX_DR]  = 1'b1;
      CODE_AR:  oh[IDX_AR]  = 1'b1;
      CODE_RR:  oh[IDX_RR]  = 1'b1;
      CODE_RT4: oh[IDX_RT4] = 1'b1;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bus_dest_regs_if.sv
// Bus-side signals of the destination-register block: requests in, register
// contents and memory write port out.
interface bus_dest_regs_if #(parameter int WIDTH = 8);
  import bus_dest_regs_pkg::*;

  logic [WIDTH-1:0]  bus_in;
  logic              wr_en;
  logic [CODE_W-1:0] wr_sel;
  logic              inc_en;
  logic [CODE_W-1:0] inc_sel;
  logic              clr_en;
  logic [CODE_W-1:0] clr_sel;

  logic [WIDTH-1:0] AR, DR, RP, RT, RM1, RK1, RN1, RM2, RK2, RN2, C1, C2, C3, AC, RR, RT4;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             ac_zero;

  modport master (
    output bus_in, wr_en, wr_sel, inc_en, inc_sel, clr_en, clr_sel,
    input  AR, DR, RP, RT, RM1, RK1, RN1, RM2, RK2, RN2, C1, C2, C3, AC, RR, RT4,
    input  mem_we, mem_addr, mem_wdata, ac_zero
  );

  modport slave (
    input  bus_in, wr_en, wr_sel, inc_en, inc_sel, clr_en, clr_sel,
    output AR, DR, RP, RT, RM1, RK1, RN1, RM2, RK2, RN2, C1, C2, C3, AC, RR, RT4,
    output mem_we, mem_addr, mem_wdata, ac_zero
  );

endinterface

// File: rtl/bus_dest_regs_reg.sv
// One bus-writable register: clear beats load, load beats increment.
module bus_dest_regs_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (ld) begin
      val_d = d;
    end else if (inc) begin
      val_d = val_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/bus_dest_regs.sv
// Write side of the datapath bus: decodes destination codes into per-register
// load/increment/clear enables and registers memory write requests.
module bus_dest_regs
  import bus_dest_regs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  bus_dest_regs_if.slave  bus
);

  logic [NUM_REGS-1:0] ld_vec;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [WIDTH-1:0]    reg_val [NUM_REGS];

  always_comb begin
    ld_vec  = bus.wr_en  ? code_onehot(bus.wr_sel)  : '0;
    inc_vec = bus.inc_en ? code_onehot(bus.inc_sel) : '0;
    clr_vec = bus.clr_en ? code_onehot(bus.clr_sel) : '0;
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    bus_dest_regs_reg #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .clr (clr_vec[gi]),
      .ld  (ld_vec[gi]),
      .inc (inc_vec[gi]),
      .d   (bus.bus_in),
      .q   (reg_val[gi])
    );
  end

  assign bus.AC  = reg_val[IDX_AC];
  assign bus.C3  = reg_val[IDX_C3];
  assign bus.C2  = reg_val[IDX_C2];
  assign bus.C1  = reg_val[IDX_C1];
  assign bus.RN2 = reg_val[IDX_RN2];
  assign bus.RK2 = reg_val[IDX_RK2];
  assign bus.RM2 = reg_val[IDX_RM2];
  assign bus.RN1 = reg_val[IDX_RN1];
  assign bus.RK1 = reg_val[IDX_RK1];
  assign bus.RM1 = reg_val[IDX_RM1];
  assign bus.RT  = reg_val[IDX_RT];
  assign bus.RP  = reg_val[IDX_RP];
  assign bus.DR  = reg_val[IDX_DR];
  assign bus.AR  = reg_val[IDX_AR];
  assign bus.RR  = reg_val[IDX_RR];
  assign bus.RT4 = reg_val[IDX_RT4];

  assign bus.ac_zero = (reg_val[IDX_AC] == '0);

  // Memory write stage: address uses AR before any same-edge AR update.
  logic             mem_we_q,    mem_we_d;
  logic [WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  always_comb begin
    mem_we_d    = bus.wr_en && (bus.wr_sel == CODE_MEM);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (mem_we_d) begin
      mem_addr_d  = reg_val[IDX_AR];
      mem_wdata_d = bus.bus_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_bus_dest_regs.sv
// Directed self-checking bench for bus_dest_regs with a per-register expected model.
module tb_bus_dest_regs;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [WIDTH-1:0] exp_reg [16];

  bus_dest_regs_if #(.WIDTH(WIDTH)) bus ();

  bus_dest_regs #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Independent slot table: 0=AC 1=C3 2=C2 3=C1 4=RN2 5=RK2 6=RM2 7=RN1
  // 8=RK1 9=RM1 10=RT 11=RP 12=DR 13=AR 14=RR 15=RT4, -1 for MEM/NONE.
  function automatic int code2idx(input int code);
    case (code)
      1: return 0;   2: return 1;   3: return 2;   4: return 3;
      5: return 4;   6: return 5;   7: return 6;   8: return 7;
      9: return 8;   10: return 9;  11: return 10; 12: return 11;
      13: return 12; 14: return 13; 16: return 14; 17: return 15;
      default: return -1;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] dut_reg(input int idx);
    case (idx)
      0: return bus.AC;   1: return bus.C3;   2: return bus.C2;   3: return bus.C1;
      4: return bus.RN2;  5: return bus.RK2;  6: return bus.RM2;  7: return bus.RN1;
      8: return bus.RK1;  9: return bus.RM1;  10: return bus.RT;  11: return bus.RP;
      12: return bus.DR;  13: return bus.AR;  14: return bus.RR;  default: return bus.RT4;
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s.r%0d", tag, i), 32'(dut_reg(i)), 32'(exp_reg[i]));
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.inc_en = 1'b0; bus.clr_en = 1'b0;
    bus.wr_sel = 5'd0; bus.inc_sel = 5'd0; bus.clr_sel = 5'd0;
    bus.bus_in = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int code, input logic [7:0] val);
    idle();
    bus.wr_en = 1'b1; bus.wr_sel = 5'(code); bus.bus_in = val;
    step();
    if (code2idx(code) >= 0) exp_reg[code2idx(code)] = val;
    idle();
  endtask

  int codes [16] = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,16,17};
  int nones [3]  = '{0,18,31};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) exp_reg[i] = 8'h00;
    idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    step();
    check_all("reset");
    check("reset.mem_we", 32'(bus.mem_we), 32'd0);

    // Asynchronous reset mid-cycle with AC nonzero
    load(1, 8'h5A);
    check("ac_load", 32'(bus.AC), 32'h5A);
    check("ac_zero_lo", 32'(bus.ac_zero), 32'd0);
    #2 rst = 1'b1;
    #1;
    exp_reg[0] = 8'h00;
    check("async_rst.AC", 32'(bus.AC), 32'h00);
    check("async_rst.ac_zero", 32'(bus.ac_zero), 32'd1);
    check("async_rst.mem_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Load sweep over every register code, then NONE codes
    foreach (codes[k]) begin
      load(codes[k], 8'(codes[k] + 8'h10));
      check_all($sformatf("load%0d", codes[k]));
    end
    foreach (nones[k]) begin
      load(nones[k], 8'hEE);
      check_all($sformatf("none%0d", nones[k]));
    end

    // Increment/clear aimed at MEM or NONE do nothing
    bus.inc_en = 1'b1; bus.inc_sel = 5'd15; bus.clr_en = 1'b1; bus.clr_sel = 5'd0;
    step();
    idle();
    check_all("inc_clr_ignored");

    // Increment wrap on C1
    load(4, 8'hFF);
    bus.inc_en = 1'b1; bus.inc_sel = 5'd4;
    step();
    check("c1_wrap0", 32'(bus.C1), 32'h00);
    step();
    check("c1_wrap1", 32'(bus.C1), 32'h01);
    idle();
    exp_reg[3] = 8'h01;

    // Same-target priority on AC
    load(1, 8'h07);
    bus.wr_en = 1'b1; bus.inc_en = 1'b1; bus.clr_en = 1'b1;
    bus.wr_sel = 5'd1; bus.inc_sel = 5'd1; bus.clr_sel = 5'd1; bus.bus_in = 8'h33;
    step();
    check("clr_wins", 32'(bus.AC), 32'h00);
    check("clr_wins.ac_zero", 32'(bus.ac_zero), 32'd1);
    bus.clr_en = 1'b0;
    step();
    check("ld_beats_inc", 32'(bus.AC), 32'h33);
    idle();
    exp_reg[0] = 8'h33;

    // Different targets in parallel: load DR, increment RP
    bus.wr_en = 1'b1; bus.wr_sel = 5'd13; bus.bus_in = 8'h77;
    bus.inc_en = 1'b1; bus.inc_sel = 5'd12;
    step();
    idle();
    exp_reg[12] = 8'h77;
    exp_reg[11] = exp_reg[11] + 8'h01;
    check_all("parallel");

    // MEM write with AR incremented on the same edge
    load(14, 8'h20);
    bus.wr_en = 1'b1; bus.wr_sel = 5'd15; bus.bus_in = 8'hC4;
    bus.inc_en = 1'b1; bus.inc_sel = 5'd14;
    step();
    idle();
    check("mem.we", 32'(bus.mem_we), 32'd1);
    check("mem.addr", 32'(bus.mem_addr), 32'h20);
    check("mem.wdata", 32'(bus.mem_wdata), 32'hC4);
    check("mem.AR", 32'(bus.AR), 32'h21);
    step();
    check("mem.we_off", 32'(bus.mem_we), 32'd0);
    check("mem.addr_hold", 32'(bus.mem_addr), 32'h20);
    check("mem.wdata_hold", 32'(bus.mem_wdata), 32'hC4);

    // Back-to-back writes with fresh address each cycle
    bus.wr_en = 1'b1; bus.wr_sel = 5'd15; bus.bus_in = 8'h11;
    bus.inc_en = 1'b1; bus.inc_sel = 5'd14;
    step();
    check("b2b0.addr", 32'(bus.mem_addr), 32'h21);
    check("b2b0.wdata", 32'(bus.mem_wdata), 32'h11);
    bus.bus_in = 8'h22;
    step();
    check("b2b1.we", 32'(bus.mem_we), 32'd1);
    check("b2b1.addr", 32'(bus.mem_addr), 32'h22);
    check("b2b1.wdata", 32'(bus.mem_wdata), 32'h22);

    // Reset while the strobe is high: drops at once, none after release
    bus.inc_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid.we", 32'(bus.mem_we), 32'd0);
    check("rst_mid.AR", 32'(bus.AR), 32'h00);
    idle();
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst.we0", 32'(bus.mem_we), 32'd0);
    step();
    check("post_rst.we1", 32'(bus.mem_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
